control_in_trace_fifo: RTL and testbench

CONTROL_IN_TRACE_FIFO -- requirements
Module: control_in_trace_fifo

---
 rtl/control_in_trace_fifo.sv | 111 +++++++++++
 tb/tb_control_in_trace_fifo.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_in_trace_fifo.sv
// Trace capture FIFO for completed instruction/data events.
// Qualifying events are filtered by mode, queued in order, and counted when they are dropped.
module control_in_trace_fifo #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned FLAG_W  = 3,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                completed_instr,
    input  logic                                completed_data,
    input  logic [INSTR_W-1:0]                  IR,
    input  logic [INSTR_W-1:0]                  IR_EXEC,
    input  logic [INSTR_W-1:0]                  Imem_dout,
    input  logic [FLAG_W-1:0]                   NZP,
    input  logic [FLAG_W-1:0]                   PSR,
    input  logic [1:0]                          mode,
    input  logic                                clear,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [2+3*INSTR_W+2*FLAG_W-1:0]     out_entry,
    output logic [$clog2(DEPTH):0]              level,
    output logic                                overflow,
    output logic [CNT_W-1:0]                    drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = 2 + 3*INSTR_W + 2*FLAG_W;

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic            qualify_c;
    logic            push_c;
    logic            pop_c;
    logic            full_c;
    logic            accept_c;
    logic            drop_c;
    logic [LW-1:0]   level_next_c;
    logic [EW-1:0]   entry_in_c;

    // Event filter, push/pop arbitration and next occupancy
    always_comb begin
        qualify_c = 1'b0;
        case (mode)
            2'b00:   qualify_c = completed_instr | completed_data;
            2'b01:   qualify_c = completed_instr;
            2'b10:   qualify_c = completed_data;
            default: qualify_c = completed_instr && (IR_EXEC[INSTR_W-1 -: 4] == 4'b0000);
        endcase

        push_c   = qualify_c && !clear;
        pop_c    = out_valid && out_ready && !clear;
        full_c   = (level == LW'(DEPTH));
        accept_c = push_c && (!full_c || pop_c);
        drop_c   = push_c && full_c && !pop_c;

        entry_in_c = {completed_instr, completed_data, IR_EXEC, IR, Imem_dout, NZP, PSR};

        level_next_c = level;
        case ({accept_c, pop_c})
            2'b10:   level_next_c = level + LW'(1);
            2'b01:   level_next_c = level - LW'(1);
            default: level_next_c = level;
        endcase
    end

    // Head entry is read straight from storage; storage is zeroed on reset
    assign out_entry = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (accept_c) begin
                mem[wr_ptr] <= entry_in_c;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level     <= level_next_c;
            out_valid <= (level_next_c != '0);
            if (drop_c) begin
                overflow <= 1'b1;
                if (drop_count != {CNT_W{1'b1}}) begin
                    drop_count <= drop_count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_control_in_trace_fifo.sv
// Directed bench for control_in_trace_fifo: vector table plus hand sequences for
// overflow, full-with-pop, clear, saturation (second instance with CNT_W=2) and async reset.
module tb_control_in_trace_fifo;

    localparam int unsigned EW = 56;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic           completed_instr = 1'b0;
    logic           completed_data = 1'b0;
    logic [15:0]    IR = '0;
    logic [15:0]    IR_EXEC = '0;
    logic [15:0]    Imem_dout = '0;
    logic [2:0]     NZP = '0;
    logic [2:0]     PSR = '0;
    logic [1:0]     mode = 2'b00;
    logic           clear = 1'b0;
    logic           out_ready = 1'b0;

    logic           out_valid;
    logic [EW-1:0]  out_entry;
    logic [3:0]     level;
    logic           overflow;
    logic [7:0]     drop_count;

    logic           out_valid2;
    logic [EW-1:0]  out_entry2;
    logic [3:0]     level2;
    logic           overflow2;
    logic [1:0]     drop_count2;

    control_in_trace_fifo #(.INSTR_W(16), .FLAG_W(3), .DEPTH(8), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .completed_instr(completed_instr), .completed_data(completed_data),
        .IR(IR), .IR_EXEC(IR_EXEC), .Imem_dout(Imem_dout), .NZP(NZP), .PSR(PSR),
        .mode(mode), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_entry(out_entry),
        .level(level), .overflow(overflow), .drop_count(drop_count)
    );

    control_in_trace_fifo #(.INSTR_W(16), .FLAG_W(3), .DEPTH(8), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset),
        .completed_instr(completed_instr), .completed_data(completed_data),
        .IR(IR), .IR_EXEC(IR_EXEC), .Imem_dout(Imem_dout), .NZP(NZP), .PSR(PSR),
        .mode(mode), .clear(clear),
        .out_valid(out_valid2), .out_ready(out_ready), .out_entry(out_entry2),
        .level(level2), .overflow(overflow2), .drop_count(drop_count2)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] md;
        logic       ci;
        logic       cd;
        logic [3:0] op;
        logic       rdy;
        logic       push;
        logic [3:0] lvl;
    } vec_t;

    vec_t          tbl [17];
    logic [EW-1:0] q [$];
    logic [EW-1:0] exp_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ev(input logic ci, input logic cd, input logic [3:0] op, input logic [7:0] t);
        completed_instr = ci;
        completed_data  = cd;
        IR_EXEC   = {op, 4'h0, t};
        IR        = {8'h20, t};
        Imem_dout = {8'h40, t};
        NZP       = t[2:0];
        PSR       = t[5:3];
    endtask

    function automatic logic [EW-1:0] ev(input logic ci, input logic cd, input logic [3:0] op,
                                         input logic [7:0] t);
        return {ci, cd, {op, 4'h0, t}, {8'h20, t}, {8'h40, t}, t[2:0], t[5:3]};
    endfunction

    initial begin
        // mode, ci, cd, op, ready, expect push, expected level after the edge
        tbl[0]  = '{2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0};
        tbl[1]  = '{2'b11, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'd1};
        tbl[2]  = '{2'b11, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'd1};
        tbl[3]  = '{2'b11, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 4'd1};
        tbl[4]  = '{2'b11, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'd1};
        tbl[5]  = '{2'b11, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'd2};
        tbl[6]  = '{2'b01, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 4'd2};
        tbl[7]  = '{2'b10, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 4'd3};
        tbl[8]  = '{2'b10, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 4'd3};
        tbl[9]  = '{2'b00, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 4'd4};
        tbl[10] = '{2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd3};
        tbl[11] = '{2'b00, 1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 4'd3};
        tbl[12] = '{2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd2};
        tbl[13] = '{2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd1};
        tbl[14] = '{2'b00, 1'b1, 1'b0, 4'h9, 1'b1, 1'b1, 4'd1};
        tbl[15] = '{2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0};
        tbl[16] = '{2'b00, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'd0};

        // Reset state
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_entry", 64'(out_entry), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        reset = 1'b1;
        tick();

        // Basic capture
        mode = 2'b00;
        completed_instr = 1'b1;
        IR = 16'h1234; IR_EXEC = 16'h5678; Imem_dout = 16'h9ABC; NZP = 3'b010; PSR = 3'b100;
        tick();
        set_ev(1'b0, 1'b0, 4'h0, 8'h00);
        exp_e = {1'b1, 1'b0, 16'h5678, 16'h1234, 16'h9ABC, 3'b010, 3'b100};
        chk("basic_valid", 64'(out_valid), 64'd1);
        chk("basic_level", 64'(level), 64'd1);
        chk("basic_entry", 64'(out_entry), 64'(exp_e));
        q.push_back(exp_e);

        // Table of single-cycle vectors with a scoreboard on popped entries
        for (int i = 0; i < 17; i++) begin
            mode = tbl[i].md;
            set_ev(tbl[i].ci, tbl[i].cd, tbl[i].op, 8'(i));
            out_ready = tbl[i].rdy;
            if (tbl[i].rdy && q.size() > 0) begin
                exp_e = q.pop_front();
                chk($sformatf("vec%0d_head", i), 64'(out_entry), 64'(exp_e));
            end
            if (tbl[i].push) q.push_back(ev(tbl[i].ci, tbl[i].cd, tbl[i].op, 8'(i)));
            tick();
            chk($sformatf("vec%0d_level", i), 64'(level), 64'(tbl[i].lvl));
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(tbl[i].lvl != 4'd0));
        end
        set_ev(1'b0, 1'b0, 4'h0, 8'h00);
        mode = 2'b00;
        out_ready = 1'b0;

        // Overflow: ten events into eight slots
        for (int t = 0; t < 10; t++) begin
            set_ev(1'b1, 1'b0, 4'h3, 8'(t));
            tick();
        end
        set_ev(1'b0, 1'b0, 4'h0, 8'h00);
        chk("ovf_level", 64'(level), 64'd8);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_drop", 64'(drop_count), 64'd2);
        chk("ovf_drop_w2", 64'(drop_count2), 64'd2);
        chk("ovf_head_held", 64'(out_entry), 64'(ev(1'b1, 1'b0, 4'h3, 8'd0)));

        // Full with simultaneous pop
        set_ev(1'b1, 1'b0, 4'h3, 8'd10);
        out_ready = 1'b1;
        chk("fullpop_head", 64'(out_entry), 64'(ev(1'b1, 1'b0, 4'h3, 8'd0)));
        tick();
        set_ev(1'b0, 1'b0, 4'h0, 8'h00);
        out_ready = 1'b0;
        chk("fullpop_level", 64'(level), 64'd8);
        chk("fullpop_drop", 64'(drop_count), 64'd2);
        chk("fullpop_next", 64'(out_entry), 64'(ev(1'b1, 1'b0, 4'h3, 8'd1)));

        // Drain in order
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d", k), 64'(out_entry),
                64'(ev(1'b1, 1'b0, 4'h3, (k < 7) ? 8'(k + 1) : 8'd10)));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_level", 64'(level), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_sticky", 64'(overflow), 64'd1);

        // Clear with an event at level 5
        for (int t = 20; t < 25; t++) begin
            set_ev(1'b1, 1'b0, 4'h3, 8'(t));
            tick();
        end
        chk("pre_clear_level", 64'(level), 64'd5);
        set_ev(1'b1, 1'b0, 4'h3, 8'd25);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        set_ev(1'b0, 1'b0, 4'h0, 8'h00);
        chk("clear_level", 64'(level), 64'd0);
        chk("clear_valid", 64'(out_valid), 64'd0);
        chk("clear_overflow", 64'(overflow), 64'd0);
        chk("clear_drop", 64'(drop_count), 64'd0);
        tick();
        chk("clear_discard", 64'(level), 64'd0);

        // Saturation: 14 events, 6 dropped
        for (int t = 30; t < 44; t++) begin
            set_ev(1'b1, 1'b0, 4'h3, 8'(t));
            tick();
        end
        chk("sat_drop_w8", 64'(drop_count), 64'd6);
        chk("sat_drop_w2", 64'(drop_count2), 64'd3);
        chk("sat_level", 64'(level), 64'd8);

        // Asynchronous reset mid-burst, held across an edge with an event present
        set_ev(1'b1, 1'b0, 4'h3, 8'd50);
        #2 reset = 1'b0;
        #1;
        chk("async_valid", 64'(out_valid), 64'd0);
        chk("async_level", 64'(level), 64'd0);
        chk("async_entry", 64'(out_entry), 64'd0);
        chk("async_overflow", 64'(overflow), 64'd0);
        chk("async_drop", 64'(drop_count), 64'd0);
        chk("async_valid_w2", 64'(out_valid2), 64'd0);
        tick();
        chk("rst_edge_level", 64'(level), 64'd0);
        reset = 1'b1;
        set_ev(1'b1, 1'b0, 4'h3, 8'd51);
        tick();
        set_ev(1'b0, 1'b0, 4'h0, 8'h00);
        chk("post_rst_level", 64'(level), 64'd1);
        chk("post_rst_head", 64'(out_entry), 64'(ev(1'b1, 1'b0, 4'h3, 8'd51)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
